// File: rtl/wishbone_sram.sv
// wishbone_sram: 32-bit single-port SRAM as a Wishbone B4 registered-feedback slave with CTI/BTE bursts
module wishbone_sram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] wishbone_adr,
  input  logic [31:0] wishbone_dat_w,
  output logic [31:0] wishbone_dat_r,
  input  logic        wishbone_cyc,
  input  logic        wishbone_stb,
  output logic        wishbone_ack,
  input  logic        wishbone_we,
  input  logic [3:0]  wishbone_sel,
  input  logic [2:0]  wishbone_cti,
  input  logic [1:0]  wishbone_bte,
  output logic        wishbone_err
);
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] a, mask, nxt, rd_addr;
  logic req, busy, cont, go, in_range, wr_en;
  logic [31:0] word;
  always_comb begin
    a = wishbone_adr[ADDR_WIDTH-1:0];
    req = wishbone_cyc & wishbone_stb;
    busy = wishbone_ack | wishbone_err;
    cont = wishbone_cti == 3'b001 || wishbone_cti == 3'b010;
    go = req & (~busy | cont);
    in_range = ~|wishbone_adr[29:ADDR_WIDTH];
    wr_en = req & wishbone_ack & wishbone_we & in_range & ~reset;
    mask = wishbone_bte == 2'b00 ? '1 :
           wishbone_bte == 2'b01 ? ADDR_WIDTH'(3) :
           wishbone_bte == 2'b10 ? ADDR_WIDTH'(7) : ADDR_WIDTH'(15);
    nxt = (a & ~mask) | ((a + ADDR_WIDTH'(1)) & mask);
    rd_addr = (~busy || wishbone_cti != 3'b010) ? a : nxt;
    word = mem[rd_addr];
    // write-first bypass so a constant burst sees the beat just written
    for (int i = 0; i < 4; i++)
      if (wr_en && rd_addr == a && wishbone_sel[i]) word[8*i+:8] = wishbone_dat_w[8*i+:8];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wishbone_ack <= 1'b0;
      wishbone_err <= 1'b0;
      wishbone_dat_r <= '0;
    end else begin
      wishbone_ack <= go & in_range;
      wishbone_err <= go & ~in_range;
      wishbone_dat_r <= (go & in_range) ? word : '0;
    end
  end
  always_ff @(posedge clk)
    if (wr_en)
      for (int i = 0; i < 4; i++)
        if (wishbone_sel[i]) mem[a][8*i+:8] <= wishbone_dat_w[8*i+:8];
endmodule

// File: tb/tb_wishbone_sram.sv
// tb_wishbone_sram: directed stimulus against a transaction-level memory model, checked every cycle
module tb_wishbone_sram;
  localparam int DEPTH = 1024;
  logic clk = 1'b0, reset = 1'b1;
  logic [29:0] adr = '0;
  logic [31:0] dat_w = '0, dat_r;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0, ack, err;
  logic [3:0] sel = '0;
  logic [2:0] cti = '0;
  logic [1:0] bte = '0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  wishbone_sram #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .reset(reset), .wishbone_adr(adr), .wishbone_dat_w(dat_w), .wishbone_dat_r(dat_r),
    .wishbone_cyc(cyc), .wishbone_stb(stb), .wishbone_ack(ack), .wishbone_we(we),
    .wishbone_sel(sel), .wishbone_cti(cti), .wishbone_bte(bte), .wishbone_err(err)
  );
  logic [31:0] mdl_mem [DEPTH];
  bit known [DEPTH];
  logic m_ack = 1'b0, m_err = 1'b0, m_known = 1'b1;
  logic [31:0] m_dat = '0;
  // expected response for the next cycle, from beat-level rules on the presented request
  always @(posedge clk) begin : model
    int a, nxt, len;
    bit busy, go, ok, wr, kn;
    logic [31:0] neww, w;
    a = int'(adr);
    ok = a < DEPTH;
    busy = m_ack || m_err;
    wr = !reset && cyc && stb && m_ack && we && ok;
    go = cyc && stb && (!busy || cti == 3'b001 || cti == 3'b010);
    if (!busy || cti == 3'b001) nxt = a;
    else if (bte == 2'b00) nxt = a + 1;
    else begin
      len = 2 << bte;
      nxt = a - a % len + (a % len + 1) % len;
    end
    nxt = nxt % DEPTH;
    neww = mdl_mem[a % DEPTH];
    for (int i = 0; i < 4; i++) if (sel[i]) neww[8*i+:8] = dat_w[8*i+:8];
    w = (wr && nxt == a) ? neww : mdl_mem[nxt];
    kn = (wr && nxt == a) ? (known[nxt] || sel == 4'hf) : known[nxt];
    if (wr) begin
      mdl_mem[a] <= neww;
      known[a] <= known[a] || sel == 4'hf;
    end
    if (reset) begin
      m_ack <= 1'b0;
      m_err <= 1'b0;
      m_dat <= '0;
      m_known <= 1'b1;
    end else begin
      m_ack <= go && ok;
      m_err <= go && !ok;
      m_dat <= (go && ok) ? w : '0;
      m_known <= !(go && ok) || kn;
    end
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    check("ack", 32'(ack), 32'(m_ack));
    check("err", 32'(err), 32'(m_err));
    if (m_known) check("dat_r", dat_r, m_dat);
  endtask
  task automatic drive(input bit c, input bit s, input bit w, input logic [29:0] a, input logic [31:0] d,
                       input logic [3:0] sl, input logic [2:0] ct, input logic [1:0] bt);
    cyc = c; stb = s; we = w; adr = a; dat_w = d; sel = sl; cti = ct; bte = bt;
    tick();
  endtask
  task automatic idle();
    drive(0, 0, 0, '0, '0, '0, '0, '0);
  endtask
  task automatic classic(input bit w, input logic [29:0] a, input logic [31:0] d, input logic [3:0] sl,
                         output logic [31:0] q, output logic a1, output logic e1, output logic a2);
    drive(1, 1, w, a, d, sl, 3'b000, 2'b00);
    a1 = ack; e1 = err; q = dat_r;
    drive(1, 1, w, a, d, sl, 3'b000, 2'b00);
    a2 = ack | err;
    idle();
  endtask
  task automatic burst4(input bit w, input logic [2:0] ct, input logic [1:0] bt, input logic [29:0] a [4],
                        input logic [31:0] d [4], output logic [31:0] q [4], output int acks);
    acks = 0;
    drive(1, 1, w, a[0], d[0], 4'hf, ct, bt);
    for (int i = 0; i < 4; i++) begin
      q[i] = dat_r;
      acks += int'(ack);
      drive(1, 1, w, a[i], d[i], 4'hf, i == 3 ? 3'b111 : ct, bt);
    end
    check("burst_end_ack", 32'(ack), 32'd0);
    idle();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
  initial begin
    int acks;
    logic [31:0] q;
    logic a1, e1, a2;
    logic [29:0] av [4];
    logic [31:0] dv [4], qv [4];
    reset = 1'b1;
    idle();
    idle();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dat", dat_r, 32'h0);
    reset = 1'b0;
    idle();
    classic(1, 30'd5, 32'hDEADBEEF, 4'hf, q, a1, e1, a2);
    check("wr5_ack", 32'(a1), 32'd1);
    check("wr5_ack_drop", 32'(a2), 32'd0);
    classic(0, 30'd5, '0, 4'hf, q, a1, e1, a2);
    check("rd5_ack", 32'(a1), 32'd1);
    check("rd5_dat", q, 32'hDEADBEEF);
    classic(1, 30'd7, 32'h11223344, 4'hf, q, a1, e1, a2);
    classic(1, 30'd7, 32'hAABBCCDD, 4'b0101, q, a1, e1, a2);
    classic(0, 30'd7, '0, 4'hf, q, a1, e1, a2);
    check("lanes_dat", q, 32'h11BB33DD);
    classic(1, 30'd0, 32'hCAFEF00D, 4'hf, q, a1, e1, a2);
    av = '{30'h10, 30'h11, 30'h12, 30'h13};
    dv = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    burst4(1, 3'b010, 2'b00, av, dv, qv, acks);
    check("wr_burst_acks", 32'(acks), 32'd4);
    burst4(0, 3'b010, 2'b00, av, dv, qv, acks);
    check("rd_burst_acks", 32'(acks), 32'd4);
    for (int i = 0; i < 4; i++) check("rd_burst_dat", qv[i], 32'hA0 + 32'(i));
    av = '{30'h20, 30'h21, 30'h22, 30'h23};
    dv = '{32'h20, 32'h21, 32'h22, 32'h23};
    burst4(1, 3'b010, 2'b00, av, dv, qv, acks);
    av = '{30'h22, 30'h23, 30'h20, 30'h21};
    burst4(0, 3'b010, 2'b01, av, dv, qv, acks);
    check("wrap4_d0", qv[0], 32'h22);
    check("wrap4_d1", qv[1], 32'h23);
    check("wrap4_d2", qv[2], 32'h20);
    check("wrap4_d3", qv[3], 32'h21);
    av = '{30'h30, 30'h30, 30'h30, 30'h30};
    dv = '{32'h50000000, 32'h50000001, 32'h50000002, 32'h50000003};
    burst4(1, 3'b001, 2'b00, av, dv, qv, acks);
    check("const_bypass1", qv[1], 32'h50000000);
    check("const_bypass2", qv[2], 32'h50000001);
    check("const_bypass3", qv[3], 32'h50000002);
    classic(0, 30'h30, '0, 4'hf, q, a1, e1, a2);
    check("const_final", q, 32'h50000003);
    drive(1, 1, 0, 30'h10, '0, 4'hf, 3'b010, 2'b00);
    check("stall_b0", dat_r, 32'hA0);
    drive(1, 1, 0, 30'h10, '0, 4'hf, 3'b010, 2'b00);
    check("stall_b1", dat_r, 32'hA1);
    drive(1, 1, 0, 30'h11, '0, 4'hf, 3'b010, 2'b00);
    check("stall_pred_ack", 32'(ack), 32'd1);
    drive(1, 0, 0, 30'h12, '0, 4'hf, 3'b010, 2'b00);
    check("stall_gap1", 32'(ack), 32'd0);
    drive(1, 0, 0, 30'h12, '0, 4'hf, 3'b010, 2'b00);
    check("stall_gap2", 32'(ack), 32'd0);
    drive(1, 1, 0, 30'h12, '0, 4'hf, 3'b010, 2'b00);
    check("resume_ack", 32'(ack), 32'd1);
    check("resume_b2", dat_r, 32'hA2);
    drive(1, 1, 0, 30'h12, '0, 4'hf, 3'b010, 2'b00);
    check("resume_b3", dat_r, 32'hA3);
    drive(1, 1, 0, 30'h13, '0, 4'hf, 3'b111, 2'b00);
    check("resume_end", 32'(ack), 32'd0);
    idle();
    drive(1, 1, 1, 30'h20, 32'hFFFFFFFF, 4'hf, 3'b010, 2'b00);
    check("rstmid_ack", 32'(ack), 32'd1);
    reset = 1'b1;
    drive(1, 1, 1, 30'h20, 32'hFFFFFFFF, 4'hf, 3'b010, 2'b00);
    check("rstmid_drop", 32'(ack), 32'd0);
    reset = 1'b0;
    idle();
    classic(0, 30'h20, '0, 4'hf, q, a1, e1, a2);
    check("rstmid_nowrite", q, 32'h20);
    classic(1, 30'h400, 32'h12345678, 4'hf, q, a1, e1, a2);
    check("oor_wr_err", 32'(e1), 32'd1);
    check("oor_wr_ack", 32'(a1), 32'd0);
    check("oor_wr_drop", 32'(a2), 32'd0);
    classic(0, 30'h400, '0, 4'hf, q, a1, e1, a2);
    check("oor_rd_err", 32'(e1), 32'd1);
    check("oor_rd_dat", q, 32'h0);
    classic(0, 30'h0, '0, 4'hf, q, a1, e1, a2);
    check("oor_adr0_intact", q, 32'hCAFEF00D);
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
